// File: rtl/alu_pkg.sv
// Shared ALU encodings, sequencer command opcodes and sequencer FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND    = 4'd0,
    ALU_EXOR   = 4'd1,
    ALU_SUB_AB = 4'd2,
    ALU_SUB_BA = 4'd3,
    ALU_ADD    = 4'd4,
    ALU_ADC    = 4'd5,
    ALU_SBC_AB = 4'd6,
    ALU_SBC_BA = 4'd7,
    ALU_ORR    = 4'd8,
    ALU_MOV    = 4'd9,
    ALU_BIC    = 4'd10,
    ALU_MVN    = 4'd11
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_EOR = 3'd3,
    OP_ORR = 3'd4,
    OP_MOV = 3'd5
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } seq_state_e;

  function automatic logic op_is_arith(input cmd_op_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_wide_op_seq_alu.sv
// Team ALU: single-word logic/arithmetic unit with ARM-style carry (C = not-borrow on subtract).
module alu_wide_op_seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_ctrl_e        ctrl,
  input  logic             ci,
  output logic [WIDTH-1:0] y,
  output logic             n,
  output logic             z,
  output logic             c,
  output logic             v
);

  logic [WIDTH-1:0] opx_s;
  logic [WIDTH-1:0] opy_s;
  logic             cin_s;
  logic             arith_s;
  logic [WIDTH:0]   sum_s;

  // Select adder operands / logic result for the requested operation
  always_comb begin
    opx_s   = a;
    opy_s   = b;
    cin_s   = 1'b0;
    arith_s = 1'b0;
    y       = {WIDTH{1'b0}};
    case (ctrl)
      ALU_AND:    y = a & b;
      ALU_EXOR:   y = a ^ b;
      ALU_ORR:    y = a | b;
      ALU_MOV:    y = b;
      ALU_BIC:    y = a & ~b;
      ALU_MVN:    y = ~b;
      ALU_ADD:    arith_s = 1'b1;
      ALU_ADC:    begin arith_s = 1'b1; cin_s = ci; end
      ALU_SUB_AB: begin arith_s = 1'b1; opy_s = ~b; cin_s = 1'b1; end
      ALU_SUB_BA: begin arith_s = 1'b1; opx_s = b; opy_s = ~a; cin_s = 1'b1; end
      ALU_SBC_AB: begin arith_s = 1'b1; opy_s = ~b; cin_s = ci; end
      ALU_SBC_BA: begin arith_s = 1'b1; opx_s = b; opy_s = ~a; cin_s = ci; end
      default:    y = {WIDTH{1'b0}};
    endcase
    sum_s = {1'b0, opx_s} + {1'b0, opy_s} + {{WIDTH{1'b0}}, cin_s};
    if (arith_s) begin
      y = sum_s[WIDTH-1:0];
      c = sum_s[WIDTH];
      v = (opx_s[WIDTH-1] == opy_s[WIDTH-1]) && (sum_s[WIDTH-1] != opx_s[WIDTH-1]);
    end else begin
      c = 1'b0;
      v = 1'b0;
    end
    n = y[WIDTH-1];
    z = (y == {WIDTH{1'b0}});
  end

endmodule

// File: rtl/alu_wide_op_seq.sv
// Multi-word ALU sequencer: streams LSW-first word pairs through one ALU, chaining carry.
// Optional build macro ALU_SEQ_CIN_EN: word 0 of ADD/SUB uses with-carry codes and cmd_cin.
module alu_wide_op_seq
  import alu_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int WORDS_MAX = 4,
  parameter int LEN_W     = $clog2(WORDS_MAX + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             cmd_cin,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_last,
  output logic [3:0]       flags_nzcv,
  output logic             done,
  output logic             err
);

  seq_state_e       state_r;
  cmd_op_e          op_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] cnt_r;
  logic             carry_r;
  logic             zacc_r;
  logic             n_r;
  logic             v_r;
  logic [WIDTH-1:0] res_data_r;
  logic             res_valid_r;
  logic             res_last_r;
  logic             cmd_ready_r;
  logic             done_r;
  logic             err_r;
  logic [3:0]       flags_r;

  logic             cmd_hs_s;
  logic             cmd_legal_s;
  logic             accept_s;
  logic             res_hs_s;
  logic             last_s;
  alu_ctrl_e        ctrl_s;
  logic [WIDTH-1:0] alu_y_s;
  logic             alu_n_s;
  logic             alu_z_s;
  logic             alu_c_s;
  logic             alu_v_s;

  function automatic alu_ctrl_e ctrl_for(input cmd_op_e op, input logic first);
    alu_ctrl_e ctrl;
    case (op)
`ifdef ALU_SEQ_CIN_EN
      OP_ADD:  ctrl = ALU_ADC;
      OP_SUB:  ctrl = ALU_SBC_AB;
`else
      OP_ADD:  ctrl = first ? ALU_ADD : ALU_ADC;
      OP_SUB:  ctrl = first ? ALU_SUB_AB : ALU_SBC_AB;
`endif
      OP_AND:  ctrl = ALU_AND;
      OP_EOR:  ctrl = ALU_EXOR;
      OP_ORR:  ctrl = ALU_ORR;
      OP_MOV:  ctrl = ALU_MOV;
      default: ctrl = ALU_MOV;
    endcase
    return ctrl;
  endfunction

`ifndef ALU_SEQ_CIN_EN
  logic cin_unused_s;
  assign cin_unused_s = cmd_cin;
`endif

  assign cmd_hs_s    = cmd_valid && cmd_ready_r;
  assign cmd_legal_s = (cmd_op <= 3'd5) && (cmd_len != LEN_W'(0)) && (cmd_len <= LEN_W'(WORDS_MAX));
  assign in_ready    = (state_r == ST_RUN) && (!res_valid_r || res_ready);
  assign accept_s    = in_valid && in_ready;
  assign res_hs_s    = res_valid_r && res_ready;
  assign last_s      = (cnt_r == len_r - LEN_W'(1));
  assign ctrl_s      = ctrl_for(op_r, cnt_r == LEN_W'(0));

  alu_wide_op_seq_alu #(.WIDTH(WIDTH)) u_alu (
    .a    (in_a),
    .b    (in_b),
    .ctrl (ctrl_s),
    .ci   (carry_r),
    .y    (alu_y_s),
    .n    (alu_n_s),
    .z    (alu_z_s),
    .c    (alu_c_s),
    .v    (alu_v_s)
  );

  // Sequencer FSM with registered result word, handshakes and completion pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_ADD;
      len_r       <= LEN_W'(0);
      cnt_r       <= LEN_W'(0);
      carry_r     <= 1'b0;
      zacc_r      <= 1'b1;
      n_r         <= 1'b0;
      v_r         <= 1'b0;
      res_data_r  <= {WIDTH{1'b0}};
      res_valid_r <= 1'b0;
      res_last_r  <= 1'b0;
      cmd_ready_r <= 1'b1;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
      flags_r     <= 4'd0;
    end else begin
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      flags_r <= 4'd0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_hs_s) begin
            if (cmd_legal_s) begin
              op_r        <= cmd_op_e'(cmd_op);
              len_r       <= cmd_len;
              cnt_r       <= LEN_W'(0);
              zacc_r      <= 1'b1;
`ifdef ALU_SEQ_CIN_EN
              carry_r     <= op_is_arith(cmd_op_e'(cmd_op)) ? cmd_cin : 1'b0;
`else
              carry_r     <= 1'b0;
`endif
              cmd_ready_r <= 1'b0;
              state_r     <= ST_RUN;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept_s) begin
            res_data_r  <= alu_y_s;
            res_valid_r <= 1'b1;
            res_last_r  <= last_s;
            carry_r     <= op_is_arith(op_r) ? alu_c_s : 1'b0;
            zacc_r      <= zacc_r & alu_z_s;
            n_r         <= alu_n_s;
            v_r         <= alu_v_s;
            cnt_r       <= cnt_r + LEN_W'(1);
            if (last_s) begin
              state_r <= ST_DRAIN;
            end
          end else if (res_hs_s) begin
            res_valid_r <= 1'b0;
          end
        end
        ST_DRAIN: begin
          if (res_hs_s && res_last_r) begin
            res_valid_r <= 1'b0;
            res_last_r  <= 1'b0;
            done_r      <= 1'b1;
            flags_r     <= {n_r, zacc_r, carry_r, v_r};
            cmd_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          cmd_ready_r <= 1'b1;
          res_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign res_valid  = res_valid_r;
  assign res_data   = res_data_r;
  assign res_last   = res_last_r;
  assign flags_nzcv = flags_r;
  assign done       = done_r;
  assign err        = err_r;

endmodule
